cyclic_light_checker: RTL

- Passive sequence checker for the 3-lamp cyclic traffic-light output. It is the receiving end of the `light` interface.
- Samples `light[0:2]` (RGY) every clock, locks onto the Red→Green→Yellow→Red cycle and checks one-hot encoding, colour order and per-colour dwell time.
- Reports errors, counts completed cycles, and sits beside the lamp controller in benches and on-chip self-test.

---
 rtl/cyclic_light_checker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cyclic_light_checker.sv
// Passive checker for the R->G->Y lamp cycle: one-hot encoding, colour order and per-colour dwell.
// Define CYCLIC_CHECKER_STICKY_EN to latch the first error into a terminal fault until reset.
module cyclic_light_checker #(
   parameter int R_TIME = 1,
   parameter int G_TIME = 1,
   parameter int Y_TIME = 1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [0:2]       light,
   output logic             locked,
   output logic [1:0]       state,
   output logic             err_pulse,
   output logic [1:0]       err_code,
   output logic [7:0]       err_count,
   output logic [CNT_W-1:0] cycle_count
);

   typedef enum logic [1:0] {SYNC = 2'b00, RED = 2'b01, GREEN = 2'b10, YELLOW = 2'b11} state_t;

   localparam logic [1:0] E_NONE  = 2'b00;
   localparam logic [1:0] E_ILL   = 2'b01;
   localparam logic [1:0] E_SEQ   = 2'b10;
   localparam logic [1:0] E_DWELL = 2'b11;

   localparam logic [7:0] R_T = 8'(R_TIME);
   localparam logic [7:0] G_T = 8'(G_TIME);
   localparam logic [7:0] Y_T = 8'(Y_TIME);

   state_t           state_q, state_d;
   state_t           col, nxt_col;
   logic             onehot;
   logic [0:2]       prev_q;
   logic [7:0]       dwell_q, dwell_d;
   logic [7:0]       cur_time;
   logic [1:0]       err;
   logic             cyc_inc;
   logic             err_pulse_q;
   logic [1:0]       err_code_q;
   logic [7:0]       err_count_q;
   logic [CNT_W-1:0] cycle_q;
   logic             fault_q;

`ifdef CYCLIC_CHECKER_STICKY_EN
   // Once set, SYNC can never relock, so no further errors can be raised either.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              fault_q <= 1'b0;
      else if (err != E_NONE)  fault_q <= 1'b1;
   end
`else
   assign fault_q = 1'b0;
`endif

   always_comb begin
      col    = SYNC;
      onehot = 1'b1;
      case (light)
         3'b100:  col = RED;
         3'b010:  col = GREEN;
         3'b001:  col = YELLOW;
         default: onehot = 1'b0;
      endcase
   end

   always_comb begin
      cur_time = Y_T;
      nxt_col  = RED;
      case (state_q)
         RED:     begin cur_time = R_T; nxt_col = GREEN;  end
         GREEN:   begin cur_time = G_T; nxt_col = YELLOW; end
         default: begin cur_time = Y_T; nxt_col = RED;    end
      endcase
   end

   // Classification is mutually exclusive, which yields ILLEGAL > SEQ > DWELL priority.
   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      err     = E_NONE;
      cyc_inc = 1'b0;
      if (state_q == SYNC) begin
         if (!fault_q && light == 3'b100 && prev_q != 3'b100) begin
            state_d = RED;
            dwell_d = 8'd1;
         end
      end else if (!onehot) begin
         err = E_ILL;
      end else if (col == state_q) begin
         if (({1'b0, dwell_q} + 9'd1) > {1'b0, cur_time}) err = E_DWELL;
         else                                             dwell_d = dwell_q + 8'd1;
      end else if (col == nxt_col) begin
         if (dwell_q == cur_time) begin
            state_d = col;
            dwell_d = 8'd1;
            cyc_inc = (state_q == YELLOW);
         end else begin
            err = E_DWELL;
         end
      end else begin
         err = E_SEQ;
      end
      if (err != E_NONE) begin
         state_d = SYNC;
         dwell_d = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SYNC;
         prev_q      <= 3'b000;
         dwell_q     <= 8'd0;
         err_pulse_q <= 1'b0;
         err_code_q  <= E_NONE;
         err_count_q <= 8'd0;
         cycle_q     <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= light;
         dwell_q     <= dwell_d;
         err_pulse_q <= (err != E_NONE);
         if (err != E_NONE) begin
            err_code_q <= err;
            if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
         end
         if (cyc_inc && cycle_q != {CNT_W{1'b1}}) cycle_q <= cycle_q + CNT_W'(1);
      end
   end

   assign state       = state_q;
   assign locked      = (state_q != SYNC);
   assign err_pulse   = err_pulse_q;
   assign err_code    = err_code_q;
   assign err_count   = err_count_q;
   assign cycle_count = cycle_q;

endmodule
